// File: rtl/dmem_wbuf_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_wbuf_responder_if : core data-port bundle plus write-buffer status
// Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_wbuf_responder_if #(
  parameter int WB_DEPTH = 4
);
  localparam int CW = $clog2(WB_DEPTH + 1);

  logic          memwrite;
  logic [31:0]   aluout;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [CW-1:0] wb_count;
  logic          wb_full;
  logic          wb_empty;

  modport master (
    output memwrite, aluout, writedata,
    input  readdata, wb_count, wb_full, wb_empty
  );

  modport slave (
    input  memwrite, aluout, writedata,
    output readdata, wb_count, wb_full, wb_empty
  );
endinterface
`default_nettype wire

// File: rtl/dmem_wbuf_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_wbuf_responder : posted-store write buffer draining into a slow RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_wbuf_responder #(
  parameter int ADDR_W    = 8,
  parameter int WB_DEPTH  = 4,
  parameter int DRAIN_LAT = 3
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  dmem_wbuf_responder_if.slave   bus
);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int TW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DRAIN_LAT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(WB_DEPTH);

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] ent_idx  [WB_DEPTH];
  logic [31:0]       ent_data [WB_DEPTH];
  logic [31:0]       ram      [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic              full;
  logic              empty;
  logic              push;
  logic              drain;
  logic [PW-1:0]     pos;
  logic [31:0]       rdata;
  logic              unused_addr_bits;

  assign idx              = bus.aluout[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.aluout[31:ADDR_W+2], bus.aluout[1:0]};
  assign full             = (count == COUNT_FULL);
  assign empty            = (count == '0);
  assign push             = bus.memwrite;
  // A store into a full buffer forces the head out so nothing is ever dropped.
  assign drain            = (!empty && (timer == TIMER_LAST)) || (push && full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      timer <= '0;
    end else begin
      if (push)
        tail <= tail + PW'(1);
      if (drain)
        head <= head + PW'(1);
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drain || empty)
        timer <= '0;
      else
        timer <= timer + TW'(1);
    end
  end

  // Entry storage and RAM are plain arrays; valid entries are tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_idx[tail]  <= idx;
      ent_data[tail] <= bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (drain)
      ram[ent_idx[head]] <= ent_data[head];
  end

  // Walk oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    rdata = ram[idx];
    pos   = head;
    for (int k = 0; k < WB_DEPTH; k++) begin
      pos = head + PW'(k);
      if ((CW'(k) < count) && (ent_idx[pos] == idx))
        rdata = ent_data[pos];
    end
  end

  assign bus.readdata = rdata;
  assign bus.wb_count = count;
  assign bus.wb_full  = full;
  assign bus.wb_empty = empty;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wbuf_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_wbuf_responder : directed bench over three drain-latency variants
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_wbuf_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_wbuf_responder_if #(.WB_DEPTH(4)) bus_d ();
  dmem_wbuf_responder_if #(.WB_DEPTH(4)) bus_f ();
  dmem_wbuf_responder_if #(.WB_DEPTH(4)) bus_s ();

  assign bus_d.memwrite = memwrite;  assign bus_d.aluout = aluout;  assign bus_d.writedata = writedata;
  assign bus_f.memwrite = memwrite;  assign bus_f.aluout = aluout;  assign bus_f.writedata = writedata;
  assign bus_s.memwrite = memwrite;  assign bus_s.aluout = aluout;  assign bus_s.writedata = writedata;

  dmem_wbuf_responder #(.ADDR_W(8), .WB_DEPTH(4), .DRAIN_LAT(3)) u_dut  (.clk(clk), .reset_n(reset_n), .bus(bus_d));
  dmem_wbuf_responder #(.ADDR_W(8), .WB_DEPTH(4), .DRAIN_LAT(1)) u_fast (.clk(clk), .reset_n(reset_n), .bus(bus_f));
  dmem_wbuf_responder #(.ADDR_W(8), .WB_DEPTH(4), .DRAIN_LAT(8)) u_slow (.clk(clk), .reset_n(reset_n), .bus(bus_s));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    memwrite  = 1'b1;
    aluout    = addr;
    writedata = data;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic read_all(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    aluout = addr;
    #1;
    check({tag, "/lat3"}, bus_d.readdata, exp);
    check({tag, "/lat1"}, bus_f.readdata, exp);
    check({tag, "/lat8"}, bus_s.readdata, exp);
  endtask

  task automatic wait_empty(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      done = bus_d.wb_empty && bus_f.wb_empty && bus_s.wb_empty;
      if (done) break;
      tick();
    end
    check({tag, "_drain_timeout"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    memwrite  = 1'b0;
    aluout    = '0;
    writedata = '0;
    #12;
    check("rst_count", {29'b0, bus_d.wb_count}, 32'd0);
    check("rst_empty", {31'b0, bus_d.wb_empty}, 32'd1);
    check("rst_full",  {31'b0, bus_d.wb_full},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single store: visible next cycle, drains after three cycles at the head.
    store(32'h10, 32'hDEADBEEF);
    aluout = 32'h10;
    #1;
    check("t1_fwd",    bus_d.readdata, 32'hDEADBEEF);
    check("t1_cnt1",   {29'b0, bus_d.wb_count}, 32'd1);
    tick();
    tick();
    check("t1_cnt_e3", {29'b0, bus_d.wb_count}, 32'd1);
    tick();
    check("t1_cnt_e4", {29'b0, bus_d.wb_count}, 32'd0);
    read_all("t1_ram", 32'h10, 32'hDEADBEEF);

    // Two stores to one word back-to-back: no same-cycle bypass, youngest wins.
    wait_empty("t2");
    memwrite  = 1'b1;
    aluout    = 32'h20;
    writedata = 32'h1111;
    tick();
    check("t2_first", bus_d.readdata, 32'h1111);
    writedata = 32'h2222;
    tick();
    memwrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_all("t2_young", 32'h20, 32'h2222);
      tick();
    end
    wait_empty("t2");
    read_all("t2_ram", 32'h20, 32'h2222);

    // Fill the long-latency buffer, then a fifth store forces a drain.
    wait_empty("t3");
    store(32'h0, 32'hA0);
    store(32'h4, 32'hA1);
    store(32'h8, 32'hA2);
    store(32'hC, 32'hA3);
    check("t3_full",  {31'b0, bus_s.wb_full},  32'd1);
    check("t3_cnt4",  {29'b0, bus_s.wb_count}, 32'd4);
    store(32'h10, 32'h55);
    check("t3_cnt_forced",  {29'b0, bus_s.wb_count}, 32'd4);
    check("t3_full_forced", {31'b0, bus_s.wb_full},  32'd1);
    read_all("t3_w0", 32'h0,  32'hA0);
    read_all("t3_w1", 32'h4,  32'hA1);
    read_all("t3_w2", 32'h8,  32'hA2);
    read_all("t3_w3", 32'hC,  32'hA3);
    read_all("t3_w4", 32'h10, 32'h55);

    // Index aliasing through ignored upper and byte-offset bits.
    wait_empty("t4");
    store(32'h403, 32'hA5A5A5A5);
    read_all("t4_alias0",  32'h000, 32'hA5A5A5A5);
    read_all("t4_byteoff", 32'h13,  32'h55);
    wait_empty("t4");
    read_all("t4_ram_hi", 32'hFFFFFC00, 32'hA5A5A5A5);

    // Async reset mid-cycle discards pending stores; RAM survives.
    store(32'h40, 32'h77);
    store(32'h44, 32'h66);
    store(32'h48, 32'h55);
    wait_empty("t5");
    memwrite = 1'b1;
    aluout = 32'h40; writedata = 32'h99; tick();
    aluout = 32'h44; writedata = 32'hAA; tick();
    aluout = 32'h48; writedata = 32'hBB; tick();
    memwrite = 1'b0;
    check("t5_pending", {29'b0, bus_d.wb_count}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_cnt",   {29'b0, bus_d.wb_count}, 32'd0);
    check("t5_rst_empty", {31'b0, bus_d.wb_empty}, 32'd1);
    check("t5_rst_cnt8",  {29'b0, bus_s.wb_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    aluout = 32'h40; #1; check("t5_w40",  bus_d.readdata, 32'h77);
    aluout = 32'h44; #1; check("t5_w44",  bus_d.readdata, 32'h66);
    aluout = 32'h48; #1; check("t5_w48",  bus_d.readdata, 32'h55);
    aluout = 32'h40; #1; check("t5_w40s", bus_s.readdata, 32'h77);

    // One-cycle drain latency keeps at most one entry under continuous stores.
    wait_empty("t6");
    for (int i = 0; i < 10; i++) begin
      store(32'h80 + 32'(4 * i), 32'h6000_0000 + 32'(i));
      check("t6_cnt_lat1", {29'b0, bus_f.wb_count}, 32'd1);
    end
    wait_empty("t6");
    for (int i = 0; i < 10; i++)
      read_all("t6_read", 32'h80 + 32'(4 * i), 32'h6000_0000 + 32'(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
